// File: rtl/qeciphy_rx_word_aligner.sv
// -----------------------------------------------------------------------------
// qeciphy_rx_word_aligner
//
// Receive-side word-alignment controller for the GTH wrapper, running in the
// rxusrclk2 domain. Each decoded 32-bit RX word is classified as good, bad or
// neutral from its K28.5 comma positions and its per-byte code errors. The
// controller walks the transceiver's rxslide handshake until commas land in
// COMMA_LANE, declares lock after LOCK_COUNT consecutive good commas, drops
// lock after UNLOCK_COUNT bad events without an intervening good comma, and
// raises a datapath reset request when alignment cannot be found.
//
// Ports:
//   clk              rxusrclk2
//   rst_n            asynchronous active-low reset
//   enable_i         RX reset-done; low forces IDLE from any state
//   rx_data_i        decoded RX word
//   rx_charisk_i     per-byte K flag
//   rx_disperr_i     per-byte disparity error
//   rx_notintable_i  per-byte not-in-table error
//   rxsliderdy_i     slide-complete indication from the transceiver
//   rxslide_o        one-cycle slide request
//   aligned_o        word alignment locked
//   reset_req_o      RX datapath reset request
//   slide_count_o    slides issued in the current search
// -----------------------------------------------------------------------------
module qeciphy_rx_word_aligner #(
   parameter int COMMA_LANE     = 0,
   parameter int LOCK_COUNT     = 64,
   parameter int UNLOCK_COUNT   = 4,
   parameter int MAX_SLIDES     = 40,
   parameter int SLIDE_WAIT     = 32,
   parameter int SEARCH_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable_i,
   input  logic [31:0] rx_data_i,
   input  logic [3:0]  rx_charisk_i,
   input  logic [3:0]  rx_disperr_i,
   input  logic [3:0]  rx_notintable_i,
   input  logic        rxsliderdy_i,
   output logic        rxslide_o,
   output logic        aligned_o,
   output logic        reset_req_o,
   output logic [7:0]  slide_count_o
);

   localparam logic [7:0]  K28_5       = 8'hBC;
   localparam logic [3:0]  LANE_MASK   = 4'b0001 << COMMA_LANE;
   localparam logic [7:0]  LOCK_LAST   = 8'(LOCK_COUNT - 1);
   localparam logic [7:0]  UNLOCK_LAST = 8'(UNLOCK_COUNT - 1);
   localparam logic [7:0]  SLIDE_MAX   = 8'(MAX_SLIDES);
   localparam logic [7:0]  WAIT_LAST   = 8'(SLIDE_WAIT - 1);
   localparam logic [15:0] TMO_LAST    = 16'(SEARCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_SLIDE,
      ST_WAIT,
      ST_LOCKED,
      ST_RESET_REQ
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  good_cnt_q, good_cnt_d;
   logic [7:0]  bad_cnt_q, bad_cnt_d;
   logic [7:0]  slide_cnt_q, slide_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        rdy_seen_q, rdy_seen_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   logic [3:0]  comma_lane;
   logic        code_err;
   logic        any_comma;
   logic        is_good;
   logic        is_bad;

   // ---- word classification (combinational from the current inputs) ----
   always_comb begin
      comma_lane = '0;
      for (int n = 0; n < 4; n++) begin
         comma_lane[n] = rx_charisk_i[n] && (rx_data_i[8*n +: 8] == K28_5);
      end
   end

   assign code_err  = |(rx_disperr_i | rx_notintable_i);
   assign any_comma = |comma_lane;
   // A good word carries exactly one comma, and it sits in the target lane.
   assign is_good   = !code_err && (comma_lane == LANE_MASK);
   assign is_bad    = code_err || (|(comma_lane & ~LANE_MASK));

   // ---- next-state and counter update ----
   always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      slide_cnt_d = slide_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      rdy_seen_d  = rdy_seen_q;
      tmo_cnt_d   = tmo_cnt_q;

      if (!enable_i) begin
         // Dropping enable wins over everything, including a slide about to issue.
         state_d     = ST_IDLE;
         good_cnt_d  = '0;
         bad_cnt_d   = '0;
         slide_cnt_d = '0;
         wait_cnt_d  = '0;
         rdy_seen_d  = 1'b0;
         tmo_cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_SEARCH;
               good_cnt_d  = '0;
               tmo_cnt_d   = '0;
               slide_cnt_d = '0;
            end

            ST_SEARCH: begin
               tmo_cnt_d = any_comma ? 16'd0 : tmo_cnt_q + 16'd1;
               // A comma-free stream for the full timeout is treated as a dead
               // link, ahead of any slide decision in the same cycle.
               if (!any_comma && (tmo_cnt_q == TMO_LAST)) begin
                  state_d = ST_RESET_REQ;
               end else if (is_good) begin
                  good_cnt_d = good_cnt_q + 8'd1;
                  if (good_cnt_q == LOCK_LAST) begin
                     state_d   = ST_LOCKED;
                     bad_cnt_d = '0;
                  end
               end else if (is_bad) begin
                  good_cnt_d = '0;
                  if (slide_cnt_q == SLIDE_MAX) begin
                     state_d = ST_RESET_REQ;
                  end else begin
                     state_d     = ST_SLIDE;
                     slide_cnt_d = sat_inc8(slide_cnt_q);
                  end
               end
            end

            ST_SLIDE: begin
               state_d    = ST_WAIT;
               wait_cnt_d = '0;
               rdy_seen_d = 1'b0;
            end

            ST_WAIT: begin
               // Data is not trusted until the slide has settled; only the
               // ready handshake and the settle counter matter here.
               if (!rdy_seen_q) begin
                  if (rxsliderdy_i) begin
                     rdy_seen_d = 1'b1;
                     wait_cnt_d = '0;
                  end
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_d    = ST_SEARCH;
                  good_cnt_d = '0;
                  tmo_cnt_d  = '0;
                  rdy_seen_d = 1'b0;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end

            ST_LOCKED: begin
               if (is_bad) begin
                  if (bad_cnt_q == UNLOCK_LAST) begin
                     state_d     = ST_SEARCH;
                     good_cnt_d  = '0;
                     bad_cnt_d   = '0;
                     tmo_cnt_d   = '0;
                     slide_cnt_d = '0;
                  end else begin
                     bad_cnt_d = bad_cnt_q + 8'd1;
                  end
               end else if (is_good) begin
                  bad_cnt_d = '0;
               end
            end

            ST_RESET_REQ: begin
               state_d = ST_RESET_REQ;
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // ---- state, counters and registered outputs ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         good_cnt_q    <= '0;
         bad_cnt_q     <= '0;
         slide_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         rdy_seen_q    <= 1'b0;
         tmo_cnt_q     <= '0;
         rxslide_o     <= 1'b0;
         aligned_o     <= 1'b0;
         reset_req_o   <= 1'b0;
         slide_count_o <= '0;
      end else begin
         state_q       <= state_d;
         good_cnt_q    <= good_cnt_d;
         bad_cnt_q     <= bad_cnt_d;
         slide_cnt_q   <= slide_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         rdy_seen_q    <= rdy_seen_d;
         tmo_cnt_q     <= tmo_cnt_d;
         // Outputs are decoded from the next state so they line up with it.
         rxslide_o     <= (state_d == ST_SLIDE);
         aligned_o     <= (state_d == ST_LOCKED);
         reset_req_o   <= (state_d == ST_RESET_REQ);
         slide_count_o <= slide_cnt_d;
      end
   end

endmodule

// File: tb/tb_qeciphy_rx_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_qeciphy_rx_word_aligner
//
// Drives directed and randomized RX word streams into the aligner. A
// behavioural model of the alignment rules predicts the four outputs for every
// clock; the driver queues each prediction and a monitor on the falling edge
// compares it with the DUT. The driver also plays the transceiver, answering
// each slide with a ready pulse after a random delay.
// -----------------------------------------------------------------------------
module tb_qeciphy_rx_word_aligner;

   localparam int COMMA_LANE     = 0;
   localparam int LOCK_COUNT     = 64;
   localparam int UNLOCK_COUNT   = 4;
   localparam int MAX_SLIDES     = 40;
   localparam int SLIDE_WAIT     = 32;
   localparam int SEARCH_TIMEOUT = 1024;

   localparam int M_IDLE   = 0;
   localparam int M_SEARCH = 1;
   localparam int M_SLIDE  = 2;
   localparam int M_WAIT   = 3;
   localparam int M_LOCKED = 4;
   localparam int M_RESET  = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_i;
   logic [31:0] rx_data_i;
   logic [3:0]  rx_charisk_i;
   logic [3:0]  rx_disperr_i;
   logic [3:0]  rx_notintable_i;
   logic        rxsliderdy_i;
   logic        rxslide_o;
   logic        aligned_o;
   logic        reset_req_o;
   logic [7:0]  slide_count_o;

   always #5 clk = ~clk;

   qeciphy_rx_word_aligner #(
      .COMMA_LANE     (COMMA_LANE),
      .LOCK_COUNT     (LOCK_COUNT),
      .UNLOCK_COUNT   (UNLOCK_COUNT),
      .MAX_SLIDES     (MAX_SLIDES),
      .SLIDE_WAIT     (SLIDE_WAIT),
      .SEARCH_TIMEOUT (SEARCH_TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable_i        (enable_i),
      .rx_data_i       (rx_data_i),
      .rx_charisk_i    (rx_charisk_i),
      .rx_disperr_i    (rx_disperr_i),
      .rx_notintable_i (rx_notintable_i),
      .rxsliderdy_i    (rxsliderdy_i),
      .rxslide_o       (rxslide_o),
      .aligned_o       (aligned_o),
      .reset_req_o     (reset_req_o),
      .slide_count_o   (slide_count_o)
   );

   // Behavioural model state
   int m_mode;
   int m_good;
   int m_bad;
   int m_tmo;
   int m_slides;
   int m_wait_left;   // -1: still waiting for slide-ready

   int rdy_cd;        // transceiver model: cycles until ready pulse
   int n_checks = 0;
   int n_pass   = 0;
   int slide_pulses = 0;

   int sc_period;
   int sc_wrong_lane;
   int sc_slides_needed;
   int cyc;

   logic [10:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_clear();
      m_mode      = M_IDLE;
      m_good      = 0;
      m_bad       = 0;
      m_tmo       = 0;
      m_slides    = 0;
      m_wait_left = -1;
   endtask

   function automatic logic [10:0] model_out();
      return {(m_mode == M_SLIDE), (m_mode == M_LOCKED), (m_mode == M_RESET), 8'(m_slides)};
   endfunction

   // One clock of the alignment rules, applied to the word present this cycle.
   task automatic model_step(input logic rst_ok, input logic en, input logic [31:0] d,
                             input logic [3:0] k, input logic [3:0] de, input logic [3:0] nt,
                             input logic rdy);
      bit on_lane, off_lane, err, good, bad, nocomma;
      on_lane  = 0;
      off_lane = 0;
      err      = ((de | nt) != 4'd0);
      for (int n = 0; n < 4; n++) begin
         if (k[n] && (((d >> (8 * n)) & 32'hFF) == 32'hBC)) begin
            if (n == COMMA_LANE) on_lane = 1;
            else off_lane = 1;
         end
      end
      good    = !err && on_lane && !off_lane;
      bad     = err || off_lane;
      nocomma = !on_lane && !off_lane;

      if (!rst_ok || !en) begin
         model_clear();
         return;
      end
      if (m_mode == M_IDLE) begin
         m_mode = M_SEARCH; m_good = 0; m_tmo = 0; m_slides = 0;
      end else if (m_mode == M_SEARCH) begin
         m_tmo = nocomma ? m_tmo + 1 : 0;
         if (nocomma && m_tmo == SEARCH_TIMEOUT) begin
            m_mode = M_RESET;
         end else if (good) begin
            m_good++;
            if (m_good == LOCK_COUNT) begin
               m_mode = M_LOCKED; m_bad = 0;
            end
         end else if (bad) begin
            m_good = 0;
            if (m_slides == MAX_SLIDES) m_mode = M_RESET;
            else begin
               m_mode   = M_SLIDE;
               m_slides = (m_slides < 255) ? m_slides + 1 : 255;
            end
         end
      end else if (m_mode == M_SLIDE) begin
         m_mode = M_WAIT; m_wait_left = -1;
      end else if (m_mode == M_WAIT) begin
         if (m_wait_left < 0) begin
            if (rdy) m_wait_left = SLIDE_WAIT;
         end else begin
            m_wait_left--;
            if (m_wait_left == 0) begin
               m_mode = M_SEARCH; m_good = 0; m_tmo = 0; m_wait_left = -1;
            end
         end
      end else if (m_mode == M_LOCKED) begin
         if (bad) begin
            m_bad++;
            if (m_bad == UNLOCK_COUNT) begin
               m_mode = M_SEARCH; m_good = 0; m_tmo = 0; m_slides = 0; m_bad = 0;
            end
         end else if (good) begin
            m_bad = 0;
         end
      end
   endtask

   // Apply one word, predict the outputs after the next edge, advance a clock.
   task automatic step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de,
                       input logic [3:0] nt);
      logic rdy;
      rdy = 1'b0;
      if (rdy_cd > 0) begin
         rdy_cd--;
         if (rdy_cd == 0) rdy = 1'b1;
      end
      if (m_mode == M_SLIDE) rdy_cd = int'($urandom_range(1, 4));
      rx_data_i       = d;
      rx_charisk_i    = k;
      rx_disperr_i    = de;
      rx_notintable_i = nt;
      rxsliderdy_i    = rdy;
      model_step(rst_n, enable_i, d, k, de, nt, rdy);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_data();
      logic [31:0] d;
      d = $urandom;
      for (int n = 0; n < 4; n++) if (d[8*n +: 8] == 8'hBC) d[8*n +: 8] = 8'h3C;
      return d;
   endfunction

   task automatic step_filler(input logic [3:0] de, input logic [3:0] nt);
      step(rand_data(), 4'($urandom_range(0, 15)), de, nt);
   endtask

   task automatic step_comma(input logic [3:0] mask, input logic [3:0] de, input logic [3:0] nt);
      logic [31:0] d;
      d = rand_data();
      for (int n = 0; n < 4; n++) if (mask[n]) d[8*n +: 8] = 8'hBC;
      step(d, 4'($urandom_range(0, 15)) | mask, de, nt);
   endtask

   task automatic run_stream(input int n);
      for (int i = 0; i < n; i++) begin
         cyc++;
         if (cyc % sc_period != 0) step_filler(4'd0, 4'd0);
         else if (m_slides < sc_slides_needed) step_comma(4'(1 << sc_wrong_lane), 4'd0, 4'd0);
         else step_comma(4'(1 << COMMA_LANE), 4'd0, 4'd0);
      end
   endtask

   task automatic restart();
      enable_i = 1'b0;
      step_filler(4'd0, 4'd0);
      step_filler(4'd0, 4'd0);
      enable_i = 1'b1;
      cyc = 0;
   endtask

   task automatic monitor_loop();
      logic [10:0] e;
      logic [10:0] a;
      forever begin
         @(negedge clk);
         if (rxslide_o === 1'b1) slide_pulses++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {rxslide_o, aligned_o, reset_req_o, slide_count_o};
            chk("cycle_outputs{slide,aligned,rreq,cnt}", 32'(a), 32'(e));
         end
      end
   endtask

   initial begin
      int base;
      int burst;
      int kind;
      bit phase_b;
      rst_n           = 1'b0;
      enable_i        = 1'b0;
      rx_data_i       = '0;
      rx_charisk_i    = '0;
      rx_disperr_i    = '0;
      rx_notintable_i = '0;
      rxsliderdy_i    = 1'b0;
      rdy_cd          = 0;
      burst           = 0;
      sc_period       = 8;
      sc_wrong_lane   = 1;
      sc_slides_needed = 0;
      cyc             = 0;
      model_clear();
      fork
         monitor_loop();
      join_none

      // Reset state
      repeat (3) step_filler(4'd0, 4'd0);
      chk("reset_rxslide", 32'(rxslide_o), 32'd0);
      chk("reset_aligned", 32'(aligned_o), 32'd0);
      chk("reset_reset_req", 32'(reset_req_o), 32'd0);
      chk("reset_slide_count", 32'(slide_count_o), 32'd0);
      rst_n = 1'b1;
      repeat (2) step_filler(4'd0, 4'd0);

      // Aligned stream: lock one cycle after the 64th comma, no slides
      base = slide_pulses;
      sc_period = 8; sc_wrong_lane = 1; sc_slides_needed = 0;
      enable_i = 1'b1; cyc = 0;
      run_stream(511);
      chk("s1_not_locked_before_64th", 32'(aligned_o), 32'd0);
      run_stream(1);
      chk("s1_locked_after_64th", 32'(aligned_o), 32'd1);
      run_stream(16);
      chk("s1_slide_count", 32'(slide_count_o), 32'd0);
      chk("s1_slide_pulses", 32'(slide_pulses - base), 32'd0);

      // Lane 2 for three slides, then lane 0
      restart();
      base = slide_pulses;
      sc_wrong_lane = 2; sc_slides_needed = 3;
      run_stream(760);
      chk("s2_aligned", 32'(aligned_o), 32'd1);
      chk("s2_slide_count", 32'(slide_count_o), 32'd3);
      chk("s2_slide_pulses", 32'(slide_pulses - base), 32'd3);

      // Error bursts while locked: 3 errors, good comma, 4 errors
      repeat (3) step_filler(4'($urandom_range(1, 15)), 4'd0);
      step_comma(4'(1 << COMMA_LANE), 4'd0, 4'd0);
      chk("s4_hold_after_burst1", 32'(aligned_o), 32'd1);
      repeat (3) step_filler(4'($urandom_range(1, 15)), 4'd0);
      chk("s4_hold_after_3_of_4", 32'(aligned_o), 32'd1);
      step_filler(4'($urandom_range(1, 15)), 4'd0);
      chk("s4_unlock_after_4th", 32'(aligned_o), 32'd0);
      chk("s4_slide_count_cleared", 32'(slide_count_o), 32'd0);

      // Comma always in lane 1: 40 slides then reset request
      restart();
      base = slide_pulses;
      sc_wrong_lane = 1; sc_slides_needed = 1000;
      run_stream(2400);
      chk("s3_reset_req", 32'(reset_req_o), 32'd1);
      chk("s3_slide_count", 32'(slide_count_o), 32'd40);
      chk("s3_slide_pulses", 32'(slide_pulses - base), 32'd40);
      enable_i = 1'b0;
      step_filler(4'd0, 4'd0);
      chk("s3_reset_req_dropped", 32'(reset_req_o), 32'd0);
      chk("s3_idle_slide_count", 32'(slide_count_o), 32'd0);

      // No commas: timeout after 1024 comma-free SEARCH cycles
      base = slide_pulses;
      sc_period = 1 << 30;
      enable_i = 1'b1; cyc = 0;
      run_stream(1024);
      chk("s5_no_req_before_timeout", 32'(reset_req_o), 32'd0);
      run_stream(1);
      chk("s5_timeout_req", 32'(reset_req_o), 32'd1);
      chk("s5_slide_pulses", 32'(slide_pulses - base), 32'd0);

      // Asynchronous reset while rxslide_o is high
      sc_period = 8;
      restart();
      sc_wrong_lane = 3; sc_slides_needed = 1000;
      for (int i = 0; i < 200; i++) begin
         if (m_mode == M_SLIDE) break;
         run_stream(1);
      end
      chk("s6_slide_before_rst", 32'(rxslide_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_rst_rxslide", 32'(rxslide_o), 32'd0);
      chk("s6_rst_aligned", 32'(aligned_o), 32'd0);
      chk("s6_rst_reset_req", 32'(reset_req_o), 32'd0);
      chk("s6_rst_slide_count", 32'(slide_count_o), 32'd0);
      exp_q.delete();
      exp_q.push_back(11'd0);
      model_clear();
      rdy_cd = 0;
      repeat (2) step_filler(4'd0, 4'd0);
      rst_n = 1'b1;
      step_filler(4'd0, 4'd0);
      chk("s6_restart_slide_count", 32'(slide_count_o), 32'd0);
      run_stream(40);

      // Randomized traffic: noisy first half, mostly-clean second half
      for (int i = 0; i < 3000; i++) begin
         phase_b = (i >= 1500);
         if (!enable_i) begin
            if ($urandom_range(0, 9) < 3) enable_i = 1'b1;
         end else if (m_mode == M_RESET) begin
            if ($urandom_range(0, 19) == 0) enable_i = 1'b0;
         end else if ($urandom_range(0, 499) == 0) begin
            enable_i = 1'b0;
         end
         kind = int'($urandom_range(0, 99));
         if (burst > 0) begin
            burst--;
            step_filler(4'($urandom_range(1, 15)), 4'd0);
         end else if (!phase_b) begin
            if (kind < 44) step_filler(4'd0, 4'd0);
            else if (kind < 47) step_filler(4'($urandom_range(1, 15)), 4'd0);
            else if (kind < 50) step_filler(4'd0, 4'($urandom_range(1, 15)));
            else if (kind < 80) step_comma(4'(1 << COMMA_LANE), 4'd0, 4'd0);
            else if (kind < 93) step_comma(4'(1 << $urandom_range(0, 3)), 4'd0, 4'd0);
            else if (kind < 96) step_comma(4'(1 << COMMA_LANE), 4'd0, 4'($urandom_range(1, 15)));
            else step_comma(4'($urandom_range(1, 15)), 4'd0, 4'd0);
         end else begin
            if (kind == 0) begin
               burst = int'($urandom_range(0, 5));
               step_filler(4'($urandom_range(1, 15)), 4'd0);
            end else if (kind < 50) step_filler(4'd0, 4'd0);
            else step_comma(4'(1 << COMMA_LANE), 4'd0, 4'd0);
         end
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/qeciphy_rx_word_aligner.md
Name: qeciphy_rx_word_aligner

Overview:
- Receive-side word-alignment controller for the GTH transceiver wrapper, in the rxusrclk2 domain.
- Inspects 32-bit decoded RX words and per-byte K/error flags for K28.5 commas.
- Drives the transceiver's rxslide handshake until commas land in the configured byte lane, then reports lock.
- Monitors the lock and requests an RX datapath reset when alignment cannot be achieved.

Parameters:
- COMMA_LANE, 0: byte lane (0-3) in which the comma must appear when aligned.
- LOCK_COUNT, 64: consecutive good commas required to declare lock (1-255).
- UNLOCK_COUNT, 4: consecutive bad events in LOCKED that drop lock (1-255).
- MAX_SLIDES, 40: slides allowed per search before a reset request (1-255).
- SLIDE_WAIT, 32: settle cycles after rxsliderdy_i before re-evaluating (1-255).
- SEARCH_TIMEOUT, 1024: cycles in SEARCH with no comma before a reset request (1-65535).

Ports:
- clk  in  1  rxusrclk2 domain clock
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  high once the RX reset-done path completes; low forces IDLE
- rx_data_i  in  32  decoded RX word from gtwiz_userdata_rx_out
- rx_charisk_i  in  4  per-byte K flag (rxctrl0[3:0])
- rx_disperr_i  in  4  per-byte disparity error (rxctrl1[3:0])
- rx_notintable_i  in  4  per-byte not-in-table error (rxctrl3[3:0])
- rxsliderdy_i  in  1  slide-complete indication from the transceiver
- rxslide_o  out  1  one-cycle slide request to the transceiver
- aligned_o  out  1  word alignment locked
- reset_req_o  out  1  RX datapath reset request
- slide_count_o  out  8  slides issued in the current search

Behaviour:
- Reset (rst_n low): state IDLE; all outputs 0; all counters 0.
- Per-cycle classification, combinational from the inputs:
  - code_err: OR of rx_disperr_i and rx_notintable_i.
  - comma in lane n: rx_charisk_i[n]=1 and rx_data_i[8n+7:8n]=8'hBC.
  - good: no code_err, and a comma in COMMA_LANE only.
  - bad: code_err, or a comma in any other lane.
  - neutral: neither good nor bad.
- Registered outputs; state changes take effect on the cycle after the qualifying input.
- IDLE: all outputs 0. Goes to SEARCH when enable_i=1. Entry to SEARCH clears good_cnt, timeout_cnt and slide_count.
- SEARCH:
  - good: good_cnt++; a good that brings good_cnt to LOCK_COUNT goes to LOCKED.
  - bad: good_cnt cleared. Goes to RESET_REQ if slide_count==MAX_SLIDES, else to SLIDE.
  - neutral: good_cnt held.
  - timeout_cnt increments on cycles with no comma in any lane and clears on any comma. Reaching SEARCH_TIMEOUT goes to RESET_REQ.
- SLIDE: rxslide_o=1 for exactly one cycle; slide_count++ (saturates at 255); then WAIT.
- WAIT:
  - rxslide_o=0; input classification ignored.
  - On rxsliderdy_i=1, waits SLIDE_WAIT further cycles, then returns to SEARCH with good_cnt=0 and timeout_cnt=0.
  - rxsliderdy_i already high on WAIT entry counts immediately.
- LOCKED:
  - aligned_o=1; slide_count_o frozen at its final value.
  - bad: bad_cnt++. good: bad_cnt=0. neutral: bad_cnt held.
  - A bad that brings bad_cnt to UNLOCK_COUNT goes to SEARCH. aligned_o falls the next cycle; slide_count clears.
- RESET_REQ: reset_req_o=1 and aligned_o=0, held until enable_i=0, then IDLE.
- enable_i=0 in any state: IDLE on the next clock, counters cleared, rxslide_o=0. Priority is over all other transitions, including a pending slide.
- Only one rxslide pulse per WAIT cycle sequence; a new slide is never issued before SLIDE_WAIT has expired.
- Asynchronous reset mid-slide: rxslide_o drops immediately.

Test Plan:
- Aligned stream, K28.5 in lane 0 every 8th word, no errors -> aligned_o rises one cycle after the 64th comma; rxslide_o never asserted; slide_count_o=0.
- Comma in lane 2 for 3 slide attempts, then lane 0 -> exactly 3 single-cycle rxslide_o pulses, each at least SLIDE_WAIT+1 cycles after rxsliderdy_i; slide_count_o=3; lock after 64 good commas.
- Comma always in lane 1 -> 40 slides, then reset_req_o=1 held; enable_i low -> reset_req_o=0 and IDLE next cycle.
- While LOCKED, inject 3 disparity errors, one good comma, then 4 errors -> lock held through the first burst; aligned_o=0 the cycle after the 4th error of the second burst.
- No commas for 1024 cycles in SEARCH -> reset_req_o asserts; rxslide_o never asserted.
- rst_n low in the cycle rxslide_o is high -> rxslide_o, aligned_o and reset_req_o are 0 immediately; after release with enable_i=1, SEARCH restarts with slide_count_o=0.
